serial_cmd_loader: RTL and testbench
====================================

# serial_cmd_loader

- Upstream command stage for the 4-bit D flip-flop register.
- Receives framed serial commands on a one-bit line, checks parity, and drives the register's `data`, synchronous `set` and synchronous `reset` inputs.
- The register loads `data` on every clock edge, so this block holds `data` stable between commands.
- SET and CLEAR commands therefore also rewrite `data`, which makes their effect persist after the one-cycle pulse.

## Interface
Parameters:
- `TIMEOUT`, default 16: consecutive idle cycles allowed mid-frame before the frame is aborted. Must be ≥2.
- `FRAME_BITS`, default 7: bits after the start bit (2 opcode + 4 payload + 1 parity). Fixed; not for override.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `sdi` input 1: serial data; sampled only when `bit_valid`=1.
- `bit_valid` input 1: qualifies `sdi` for one cycle per bit.
- `data` output 4: to the register's `data`; held between commands.
- `ff_set` output 1: one-cycle pulse to the register's `set`.
- `ff_reset` output 1: one-cycle pulse to the register's `reset`.
- `done` output 1: one-cycle pulse when a valid frame has been executed.
- `err` output 1: one-cycle pulse on a parity error or timeout.
- `busy` output 1: high while a frame is being received.

## Operation
Frame format, MSB first, one bit per `bit_valid` cycle:
- start bit = 1
- op[1], op[0]
- d[3], d[2], d[1], d[0]
- parity p
- Even parity: op ^ d ^ p over all 7 bits = 0.

Opcodes:
- 00 LOAD: `data`←d.
- 01 SET: `data`←4'hF, pulse `ff_set`.
- 10 CLEAR: `data`←4'h0, pulse `ff_reset`.
- 11 NOP: `data` unchanged.
- Payload is ignored for SET, CLEAR and NOP, but it is still covered by parity.

State machine:
- IDLE: `bit_valid`=1 with `sdi`=1 → RECV, bit count=0. `bit_valid` with `sdi`=0 is ignored.
- RECV: each `bit_valid` shifts in `sdi` and increments the count.
  - On the 7th accepted bit, execute the frame (or flag `err` on bad parity) and return to IDLE on the same edge.
  - If `bit_valid` stays low for `TIMEOUT` consecutive cycles, abort: pulse `err`, → IDLE.

Rules:
- `ff_set` and `ff_reset` are never high together.
- On a bad parity or timeout, `data` is unchanged and there is no `done`, `ff_set` or `ff_reset` pulse.
- `done` and `err` are mutually exclusive.

## Timing
- Reset values: `data`=0, `ff_set`=`ff_reset`=`done`=`err`=`busy`=0, state IDLE, counters 0. Reset wins over any simultaneous `bit_valid`.
- Reset mid-frame discards the partial frame; no `err`.
- Latency: `data`, pulses, `done` and `err` are registered and valid in the cycle after the edge that accepts the parity bit. The register captures them on the following edge.
- `busy` rises the cycle after the start bit is accepted and falls the cycle after the parity bit is accepted or the frame aborts.
- Back-to-back frames: a start bit in the cycle right after the parity bit is accepted.
- Idle counter:
  - Cleared on every accepted bit.
  - Increments in RECV on each cycle with `bit_valid`=0.
  - Abort on the edge where the counter equals `TIMEOUT`-1 and `bit_valid`=0.
  - A bit arriving on that same cycle wins; no abort.
  - Width is $clog2(`TIMEOUT`).
- Bit count: 3 bits; it does not wrap within a frame.

## Structure
- Shared package holds:
  - Opcode constants: OP_LOAD, OP_SET, OP_CLEAR, OP_NOP.
  - State encoding: ST_IDLE, ST_RECV.
  - FRAME_BITS.
  - The all-ones and all-zeros data constants.
- One sub-module: `frame_shift_reg`, a 7-bit shift-in register with enable and clear. It exposes the parallel frame and the bit count.
- FSM, timeout counter and output registers live in the top level.

## Test plan
- After reset, send LOAD 1010: `sdi` 1,0,0,1,0,1,0,0 on 8 `bit_valid` cycles → `data`=4'hA and `done`=1 one cycle after the last bit; `ff_set`=`ff_reset`=0.
- SET (1,0,1,0,0,0,0,1) with `data`=4'hA → `data`=4'hF and `ff_set`=1 for exactly one cycle. Then CLEAR (1,1,0,0,0,0,0,1) → `data`=0, `ff_reset` pulse.
- LOAD 1010 with p=1 → `err` pulse; `data` keeps its prior value; no `done`.
- `TIMEOUT`=16: start plus 3 bits, then 16 idle cycles → `err` in the cycle after the 16th idle edge, `busy`=0. A bit on the 16th idle cycle instead → no abort.
- Assert `reset` after 4 bits of a frame, then send a full LOAD 0101 → no `err` from the discarded frame; `data`=4'h5.
- Two LOAD frames back-to-back with no gap (4'h3 then 4'hC) → two `done` pulses; `data` goes 3 then C.

Source files
------------

// File: rtl/serial_cmd_loader_pkg.sv
// Shared constants, state/opcode encodings and the frame parity helper
// for the serial command loader.
package serial_cmd_loader_pkg;

  localparam int FRAME_BITS = 7;

  localparam logic [3:0] DATA_ONES  = 4'hF;
  localparam logic [3:0] DATA_ZEROS = 4'h0;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_SET   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  // Even parity across opcode, payload and parity bit.
  function automatic logic parity_ok(input logic [FRAME_BITS:0] bits);
    return ~^bits;
  endfunction

endpackage

// File: rtl/serial_cmd_loader_frame_shift_reg.sv
// Shift-in register that collects the frame bits following the start bit
// and counts how many have been accepted.
module frame_shift_reg
  import serial_cmd_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  din,
  output logic [FRAME_BITS-1:0] frame,
  output logic [2:0]            count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      frame <= '0;
      count <= '0;
    end else if (en) begin
      frame <= {frame[FRAME_BITS-2:0], din};
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/serial_cmd_loader.sv
// Receives framed serial commands, checks parity and drives the data,
// set and reset inputs of the downstream 4-bit register.
module serial_cmd_loader #(
  parameter int TIMEOUT    = 16,
  parameter int FRAME_BITS = serial_cmd_loader_pkg::FRAME_BITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sdi,
  input  logic       bit_valid,
  output logic [3:0] data,
  output logic       ff_set,
  output logic       ff_reset,
  output logic       done,
  output logic       err,
  output logic       busy
);
  import serial_cmd_loader_pkg::*;

  localparam int             CW        = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  IDLE_LAST = CW'(TIMEOUT - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(FRAME_BITS - 1);

  state_e                state_q, state_n;
  logic [CW-1:0]         idle_q, idle_n;
  logic [3:0]            data_p1, data_p0;
  logic                  set_p1, set_p0;
  logic                  clr_p1, clr_p0;
  logic                  done_p1, done_p0;
  logic                  err_p1, err_p0;

  logic [FRAME_BITS-1:0] frame;
  logic [2:0]            cnt;
  logic                  shift_en, shift_clr;

  assign shift_en  = (state_q == ST_RECV) && bit_valid;
  assign shift_clr = reset || (state_q == ST_IDLE);

  frame_shift_reg u_shift (
    .clk   (clk),
    .clr   (shift_clr),
    .en    (shift_en),
    .din   (sdi),
    .frame (frame),
    .count (cnt)
  );

  // When the parity bit arrives, frame[5:0] holds op/payload and sdi is parity.
  always_comb begin
    state_n = state_q;
    idle_n  = idle_q;
    data_p0 = data_p1;
    set_p0  = 1'b0;
    clr_p0  = 1'b0;
    done_p0 = 1'b0;
    err_p0  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        idle_n = '0;
        if (bit_valid && sdi) state_n = ST_RECV;
      end
      ST_RECV: begin
        if (bit_valid) begin
          idle_n = '0;
          if (cnt == LAST_BIT) begin
            state_n = ST_IDLE;
            if (parity_ok({frame, sdi})) begin
              done_p0 = 1'b1;
              unique case (op_e'(frame[5:4]))
                OP_LOAD:  data_p0 = frame[3:0];
                OP_SET:   begin data_p0 = DATA_ONES;  set_p0 = 1'b1; end
                OP_CLEAR: begin data_p0 = DATA_ZEROS; clr_p0 = 1'b1; end
                OP_NOP:   data_p0 = data_p1;
              endcase
            end else begin
              err_p0 = 1'b1;
            end
          end
        end else if (idle_q == IDLE_LAST) begin
          err_p0  = 1'b1;
          state_n = ST_IDLE;
          idle_n  = '0;
        end else begin
          idle_n = idle_q + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idle_q  <= '0;
      data_p1 <= DATA_ZEROS;
      set_p1  <= 1'b0;
      clr_p1  <= 1'b0;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      state_q <= state_n;
      idle_q  <= idle_n;
      data_p1 <= data_p0;
      set_p1  <= set_p0;
      clr_p1  <= clr_p0;
      done_p1 <= done_p0;
      err_p1  <= err_p0;
    end
  end

  assign data     = data_p1;
  assign ff_set   = set_p1;
  assign ff_reset = clr_p1;
  assign done     = done_p1;
  assign err      = err_p1;
  assign busy     = (state_q == ST_RECV);

endmodule

// File: tb/tb_serial_cmd_loader.sv
// Randomized and directed bench for serial_cmd_loader against a
// bit-queue reference model of the command framing rules.
module tb_serial_cmd_loader;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset, sdi, bit_valid;
  logic [3:0] data;
  logic       ff_set, ff_reset, done, err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [3:0] m_data;
  logic       m_set, m_clr, m_done, m_err;
  bit         m_in;
  int         m_idle;
  int         m_bits[$];

  serial_cmd_loader #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .sdi       (sdi),
    .bit_valid (bit_valid),
    .data      (data),
    .ff_set    (ff_set),
    .ff_reset  (ff_reset),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic v, input logic s);
    int ones, op, d;
    m_set = 1'b0; m_clr = 1'b0; m_done = 1'b0; m_err = 1'b0;
    if (r) begin
      m_in = 0; m_idle = 0; m_bits.delete(); m_data = 4'h0;
    end else if (!m_in) begin
      if (v && s) begin
        m_in = 1; m_idle = 0; m_bits.delete();
      end
    end else if (v) begin
      m_bits.push_back(int'(s));
      m_idle = 0;
      if (m_bits.size() == 7) begin
        ones = 0;
        foreach (m_bits[i]) ones += m_bits[i];
        op = m_bits[0] * 2 + m_bits[1];
        d  = m_bits[2] * 8 + m_bits[3] * 4 + m_bits[4] * 2 + m_bits[5];
        if (ones % 2 == 0) begin
          m_done = 1'b1;
          case (op)
            0: m_data = 4'(d);
            1: begin m_data = 4'hF; m_set = 1'b1; end
            2: begin m_data = 4'h0; m_clr = 1'b1; end
            default: ;
          endcase
        end else begin
          m_err = 1'b1;
        end
        m_in = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_err = 1'b1; m_in = 0; m_idle = 0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic s);
    reset = r; bit_valid = v; sdi = s;
    @(posedge clk);
    model(r, v, s);
    @(negedge clk);
    chk("data", data, m_data);
    chk("ff_set", ff_set, m_set);
    chk("ff_reset", ff_reset, m_clr);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("busy", busy, m_in);
  endtask

  task automatic send_frame(input logic [1:0] op, input logic [3:0] d,
                            input logic bad, input int maxgap);
    logic [7:0] fr;
    int gap;
    fr = {1'b1, op, d, (^{op, d}) ^ bad};
    for (int i = 7; i >= 0; i--) begin
      cycle(1'b0, 1'b1, fr[i]);
      if (i > 0 && maxgap > 0) begin
        gap = $urandom_range(0, maxgap);
        repeat (gap) cycle(1'b0, 1'b0, 1'($urandom));
      end
    end
  endtask

  initial begin
    m_data = 4'h0; m_in = 0; m_idle = 0;
    m_set = 0; m_clr = 0; m_done = 0; m_err = 0;

    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("rst_data", data, 4'h0);
    chk("rst_busy", busy, 1'b0);

    send_frame(2'b00, 4'hA, 1'b0, 0);
    chk("load_a_done", done, 1'b1);
    chk("load_a_data", data, 4'hA);
    cycle(1'b0, 1'b0, 1'b0);
    send_frame(2'b01, 4'h0, 1'b0, 0);
    chk("set_pulse", ff_set, 1'b1);
    chk("set_data", data, 4'hF);
    cycle(1'b0, 1'b0, 1'b0);
    chk("set_one_cycle", ff_set, 1'b0);
    send_frame(2'b10, 4'h0, 1'b0, 0);
    chk("clr_pulse", ff_reset, 1'b1);
    chk("clr_data", data, 4'h0);
    send_frame(2'b00, 4'hA, 1'b1, 0);
    chk("par_err", err, 1'b1);
    chk("par_no_done", done, 1'b0);
    chk("par_data", data, 4'h0);

    // timeout: start + 3 bits, then TO idle cycles
    cycle(1'b0, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    repeat (TO) cycle(1'b0, 1'b0, 1'b0);
    chk("to_err", err, 1'b1);
    chk("to_busy", busy, 1'b0);

    // a bit on the last idle cycle saves the frame (LOAD 6)
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0); cycle(1'b0, 1'b1, 1'b0); cycle(1'b0, 1'b1, 1'b0);
    repeat (TO - 1) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1); cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0); cycle(1'b0, 1'b1, 1'b0);
    chk("late_bit_done", done, 1'b1);
    chk("late_bit_data", data, 4'h6);

    // reset mid-frame, then LOAD 5
    cycle(1'b0, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    send_frame(2'b00, 4'h5, 1'b0, 0);
    chk("after_rst_data", data, 4'h5);

    // back-to-back
    send_frame(2'b00, 4'h3, 1'b0, 0);
    chk("b2b_first", data, 4'h3);
    send_frame(2'b00, 4'hC, 1'b0, 0);
    chk("b2b_second", data, 4'hC);
    chk("b2b_done", done, 1'b1);

    for (int k = 0; k < 250; k++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        cycle(1'b0, 1'b1, 1'b1);
        repeat ($urandom_range(0, 6)) cycle(1'b0, 1'b1, 1'($urandom));
        repeat ($urandom_range(TO - 2, TO + 1)) cycle(1'b0, 1'b0, 1'($urandom));
      end else if (kind == 1) begin
        cycle(1'b0, 1'b1, 1'b1);
        repeat ($urandom_range(0, 5)) cycle(1'b0, 1'b1, 1'($urandom));
        cycle(1'b1, 1'($urandom), 1'($urandom));
      end else if (kind == 2) begin
        repeat ($urandom_range(1, 4)) cycle(1'b0, 1'($urandom), 1'b0);
      end else begin
        send_frame(2'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 2));
      end
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
